// File: rtl/sine_offset_seq_pkg.sv
// Shared constants, FSM state encoding and helpers for the sine table read sequencer.
// Optional interpolation build: SINE_INTERP_EN.
package sine_offset_seq_pkg;

  localparam int SINE_CENTER = 256;
  localparam int SINE_WAVES  = 7;
  localparam int SINE_LEN    = 256;
  localparam int IDX_W       = $clog2(SINE_LEN);

  // ST_ADDR1 is only reachable in the interpolating build.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_CAPT  = 2'd2,
    ST_ADDR1 = 2'd3
  } state_t;

  function automatic logic [2:0] clamp_wave(input logic [2:0] w);
    return (int'(w) >= SINE_WAVES) ? 3'(SINE_WAVES - 1) : w;
  endfunction

  // Table entries are centred at 256, so removing the centre is an MSB flip.
  function automatic logic [8:0] to_offset(input logic [8:0] d);
    return d ^ 9'(SINE_CENTER);
  endfunction

endpackage

// File: rtl/sine_offset_seq_phase_acc.sv
// Wrapping phase accumulator: load has priority over add-step; one-cycle update.
// No backpressure; updates whenever load or add is asserted.
module sine_offset_seq_phase_acc #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         add,
  input  logic [W-1:0] step,
  output logic [W-1:0] phase
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (load) begin
      phase <= load_val;
    end else if (add) begin
      phase <= phase + step;
    end
  end

endmodule

// File: rtl/sine_offset_seq.sv
// Sine ROM read sequencer: 3-clock request-to-strobe (4 with SINE_INTERP_EN), 1-deep request queue;
// a request arriving with the queue full is dropped and flagged in sticky overrun until frame_start.
module sine_offset_seq
  import sine_offset_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 9,
  parameter int PHASE_FRAC = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_start,
  input  logic                    line_req,
  input  logic [2:0]              wave_sel,
  input  logic [PHASE_FRAC+7:0]   frame_step,
  input  logic [PHASE_FRAC+7:0]   line_step,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_dout,
  output logic [8:0]              sample,
  output logic                    sample_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int PW = IDX_W + PHASE_FRAC;

  state_t                state, state_d;
  logic                  pending, pending_d;
  logic                  overrun_d;
  logic                  valid_d;
  logic                  lphase_add;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [8:0]            sample_d;
  logic [PW-1:0]         fphase, lphase, frame_sum;
  logic [IDX_W-1:0]      lidx;

  assign frame_sum = fphase + frame_step;
  assign lidx      = lphase[PW-1 -: IDX_W];
  assign busy      = (state != ST_IDLE);

  sine_offset_seq_phase_acc #(.W(PW)) u_fphase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_start),
    .load_val (frame_sum),
    .add      (1'b0),
    .step     (frame_step),
    .phase    (fphase)
  );

  // Each frame restarts the line phase from the freshly advanced frame phase.
  sine_offset_seq_phase_acc #(.W(PW)) u_lphase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (frame_start),
    .load_val (frame_sum),
    .add      (lphase_add),
    .step     (line_step),
    .phase    (lphase)
  );

`ifdef SINE_INTERP_EN
  localparam int MW = 11 + PHASE_FRAC;

  logic [PHASE_FRAC-1:0] frac_q, frac_d;
  logic [8:0]            a_q, a_d, b_off, interp;
  logic signed [9:0]     diff;
  logic signed [MW-1:0]  prod;

  assign b_off  = to_offset(rom_dout);
  assign diff   = $signed({b_off[8], b_off}) - $signed({a_q[8], a_q});
  assign prod   = $signed({{(MW-10){diff[9]}}, diff}) *
                  $signed({{(MW-PHASE_FRAC){1'b0}}, frac_q});
  assign interp = a_q + 9'(prod >>> PHASE_FRAC);
`else
  logic unused_frac;
  assign unused_frac = ^lphase[PHASE_FRAC-1:0];
`endif

  always_comb begin
    state_d    = state;
    pending_d  = pending;
    overrun_d  = overrun;
    addr_d     = rom_addr;
    sample_d   = sample;
    valid_d    = 1'b0;
    lphase_add = 1'b0;
`ifdef SINE_INTERP_EN
    frac_d     = frac_q;
    a_d        = a_q;
`endif
    if (frame_start) begin
      state_d   = ST_IDLE;
      pending_d = line_req;
      overrun_d = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A queued request is served now; a new one arriving alongside refills the slot.
          pending_d = pending & line_req;
          if (line_req || pending) begin
            addr_d  = ADDR_WIDTH'({clamp_wave(wave_sel), lidx});
            state_d = ST_ADDR;
`ifdef SINE_INTERP_EN
            frac_d  = lphase[PHASE_FRAC-1:0];
`endif
          end
        end
        ST_ADDR: begin
`ifdef SINE_INTERP_EN
          addr_d  = {rom_addr[ADDR_WIDTH-1:IDX_W], rom_addr[IDX_W-1:0] + IDX_W'(1)};
          state_d = ST_ADDR1;
`else
          state_d = ST_CAPT;
`endif
        end
`ifdef SINE_INTERP_EN
        ST_ADDR1: begin
          a_d     = to_offset(rom_dout);
          state_d = ST_CAPT;
        end
`endif
        ST_CAPT: begin
`ifdef SINE_INTERP_EN
          sample_d = interp;
`else
          sample_d = to_offset(rom_dout);
`endif
          valid_d    = 1'b1;
          lphase_add = 1'b1;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (line_req && (state != ST_IDLE)) begin
        if (pending) begin
          overrun_d = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      pending      <= 1'b0;
      overrun      <= 1'b0;
      rom_addr     <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
`ifdef SINE_INTERP_EN
      frac_q       <= '0;
      a_q          <= '0;
`endif
    end else begin
      state        <= state_d;
      pending      <= pending_d;
      overrun      <= overrun_d;
      rom_addr     <= addr_d;
      sample       <= sample_d;
      sample_valid <= valid_d;
`ifdef SINE_INTERP_EN
      frac_q       <= frac_d;
      a_q          <= a_d;
`endif
    end
  end

endmodule

// File: tb/tb_sine_offset_seq.sv
// Directed bench for sine_offset_seq (default build) with a simple checkable ROM model.
module tb_sine_offset_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start;
  logic        line_req;
  logic [2:0]  wave_sel;
  logic [11:0] frame_step;
  logic [11:0] line_step;
  logic [11:0] rom_addr;
  logic [8:0]  rom_dout;
  logic [8:0]  sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  wave;
    logic [11:0] step;
    int          addr;
    int          smp;
  } vec_t;

  vec_t vt[10];

  sine_offset_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .line_req     (line_req),
    .wave_sel     (wave_sel),
    .frame_step   (frame_step),
    .line_step    (line_step),
    .rom_addr     (rom_addr),
    .rom_dout     (rom_dout),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] rom_entry(input logic [11:0] a);
    int v;
    v = 256 + int'(a[7:0]) - 128 - int'(a[10:8]);
    return 9'(v);
  endfunction

  always @(posedge clk) rom_dout <= rom_entry(rom_addr);

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, " rom_addr"}, int'(rom_addr), 0);
    check({nm, " sample"}, int'(sample), 0);
    check({nm, " sample_valid"}, int'(sample_valid), 0);
    check({nm, " busy"}, int'(busy), 0);
    check({nm, " overrun"}, int'(overrun), 0);
  endtask

  task automatic pulse_frame(input logic [11:0] step);
    @(negedge clk);
    frame_step  = step;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Counts negedges from the one after the request edge until the strobe.
  task automatic wait_strobe(input string nm, input int lat);
    int n;
    n = 1;
    while (!sample_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({nm, " latency"}, n, lat);
  endtask

  task automatic req(input string nm, input int ea, input int es);
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    wait_strobe(nm, 3);
    check({nm, " addr"}, int'(rom_addr), ea);
    check({nm, " sample"}, int'(sample), es);
  endtask

  task automatic quiet_cycles(input string nm, input int cyc);
    int seen;
    seen = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (sample_valid) seen++;
    end
    check({nm, " stray strobes"}, seen, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{3'd0, 12'h010, 'h010, 'h190};
    vt[1] = '{3'd3, 12'h0F0, 'h311, 'h18E};
    vt[2] = '{3'd6, 12'h008, 'h620, 'h19A};
    vt[3] = '{3'd7, 12'h008, 'h620, 'h19A};
    vt[4] = '{3'd1, 12'hE00, 'h121, 'h1A0};
    vt[5] = '{3'd2, 12'h000, 'h201, 'h17F};
    vt[6] = '{3'd0, 12'h7F0, 'h001, 'h181};
    vt[7] = '{3'd0, 12'h7F0, 'h080, 'h000};
    vt[8] = '{3'd5, 12'h010, 'h5FF, 'h07A};
    vt[9] = '{3'd5, 12'h000, 'h500, 'h17B};

    rst_n       = 1'b0;
    frame_start = 1'b0;
    line_req    = 1'b0;
    wave_sel    = 3'd0;
    frame_step  = 12'h000;
    line_step   = 12'h000;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Table vectors starting from lphase 0x100 (index 0x10).
    pulse_frame(12'h100);
    for (int i = 0; i < 10; i++) begin
      wave_sel  = vt[i].wave;
      line_step = vt[i].step;
      req($sformatf("vec%0d", i), vt[i].addr, vt[i].smp);
    end

    // Index walk across the table end: 0xF0, 0xFF, 0x0E, ...
    pulse_frame(12'hE00);
    wave_sel  = 3'd4;
    line_step = 12'h0F0;
    for (int k = 0; k < 20; k++) begin
      int ph;
      int idx;
      ph  = (32'hF00 + k * 32'hF0) & 32'hFFF;
      idx = ph >> 4;
      req($sformatf("wrap%0d", k), 32'h400 | idx, (idx - 132) & 32'h1FF);
    end

    // line_req held for three clocks: one served, one queued, one dropped.
    pulse_frame(12'h000);
    wave_sel  = 3'd0;
    line_step = 12'h010;
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    check("burst busy0", int'(busy), 1);
    check("burst addr0", int'(rom_addr), 'h0F0);
    @(negedge clk);
    @(negedge clk);
    line_req = 1'b0;
    check("burst valid0", int'(sample_valid), 1);
    check("burst sample0", int'(sample), 'h070);
    check("burst overrun set", int'(overrun), 1);
    @(negedge clk);
    check("burst busy1", int'(busy), 1);
    check("burst addr1", int'(rom_addr), 'h0F1);
    check("burst valid gap", int'(sample_valid), 0);
    @(negedge clk);
    @(negedge clk);
    check("burst valid1", int'(sample_valid), 1);
    check("burst sample1", int'(sample), 'h071);
    check("burst overrun sticky", int'(overrun), 1);
    quiet_cycles("burst tail", 3);
    pulse_frame(12'h000);
    check("overrun cleared", int'(overrun), 0);

    // frame_start while the read is in ADDR aborts it.
    @(negedge clk);
    frame_step = 12'h010;
    line_req   = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    check("abort busy before", int'(busy), 1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("abort busy after", int'(busy), 0);
    check("abort valid", int'(sample_valid), 0);
    quiet_cycles("abort", 4);
    req("after abort", 'h0F1, 'h071);

    // frame_start together with line_req: request queued, served from reloaded phase.
    @(negedge clk);
    frame_start = 1'b1;
    line_req    = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    line_req    = 1'b0;
    check("fs+req idle first", int'(busy), 0);
    wait_strobe("fs+req", 4);
    check("fs+req addr", int'(rom_addr), 'h0F2);
    check("fs+req sample", int'(sample), 'h072);
    check("fs+req overrun", int'(overrun), 0);

    // Reset in the middle of a read.
    @(negedge clk);
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid-read reset");
    rst_n = 1'b1;
    quiet_cycles("post reset", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
